// File: rtl/fl_frame_fifo.sv
// Store-and-forward FrameLink FIFO: frames become visible on TX only once their EOF word commits them.
// Latency: first word of a frame appears on TX 2 cycles after the edge that accepted its EOF, then 1 word/cycle.
// Backpressure: RX stalls only while the memory is full with a frame still fitting; discarded words are always taken.
// Optional statistics counters are enabled with FL_FRAME_FIFO_STATS_EN.
module fl_frame_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int ITEMS      = 64,
  localparam int REM_W     = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1,
  localparam int PTR_W     = $clog2(ITEMS) + 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic [REM_W-1:0]      RX_REM,
  input  logic                  RX_SOF_N,
  input  logic                  RX_EOF_N,
  input  logic                  RX_SOP_N,
  input  logic                  RX_EOP_N,
  input  logic                  RX_SRC_RDY_N,
  output logic                  RX_DST_RDY_N,
  input  logic                  RX_DISCARD,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic [REM_W-1:0]      TX_REM,
  output logic                  TX_SOF_N,
  output logic                  TX_EOF_N,
  output logic                  TX_SOP_N,
  output logic                  TX_EOP_N,
  output logic                  TX_SRC_RDY_N,
  input  logic                  TX_DST_RDY_N,
  output logic [PTR_W-1:0]      FRAME_RDY,
  output logic [PTR_W-1:0]      FREE,
  output logic                  FULL,
  output logic                  EMPTY
`ifdef FL_FRAME_FIFO_STATS_EN
  ,
  input  logic                  STAT_CLR,
  output logic [31:0]           STAT_ACCEPTED,
  output logic [31:0]           STAT_DROPPED
`endif
);

  localparam int AW = PTR_W - 1;
  localparam int WW = DATA_WIDTH + REM_W + 4;
  localparam logic [PTR_W-1:0] ITEMS_P = PTR_W'(ITEMS);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(ITEMS - 1);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  logic [1:0]       state, state_n;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_n, wr_commit, wr_commit_n, wr_addr;
  logic [PTR_W-1:0] rd_ptr, rd_lim, frame_cnt, occ, inprog;
  logic [WW-1:0]    mem [ITEMS];
  logic [WW-1:0]    tx_word;
  logic             tx_vld, tx_take, tx_load, tx_eof_take;
  logic             rx_rdy, rx_xfer, full, mem_we, frame_commit;

  assign occ     = wr_ptr - rd_ptr;
  assign inprog  = wr_ptr - wr_commit;
  assign full    = (occ == ITEMS_P);
  // When full, only words that will be thrown away (non-SOF outside a frame) may pass.
  assign rx_rdy  = !RESET && (!full || (RX_SOF_N && state != S_WRITE));
  assign rx_xfer = !RX_SRC_RDY_N && rx_rdy;

  // RX frame FSM: speculative writes, commit on EOF, rollback on discard/overflow/restart.
  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    wr_commit_n  = wr_commit;
    mem_we       = 1'b0;
    frame_commit = 1'b0;
    // A SOF always restarts at the committed boundary, which also drops any partial frame.
    wr_addr      = RX_SOF_N ? wr_ptr : wr_commit;
    if (rx_xfer) begin
      if (!RX_SOF_N || state == S_WRITE) begin
        mem_we = 1'b1;
        if (!RX_EOF_N) begin
          state_n = S_IDLE;
          if (RX_DISCARD) begin
            wr_ptr_n = wr_commit;
          end else begin
            wr_ptr_n     = wr_addr + ONE_P;
            wr_commit_n  = wr_addr + ONE_P;
            frame_commit = 1'b1;
          end
        end else if (RX_SOF_N && inprog == LAST_P) begin
          wr_ptr_n = wr_commit;
          state_n  = S_DROP;
        end else begin
          wr_ptr_n = wr_addr + ONE_P;
          state_n  = S_WRITE;
        end
      end else if (state == S_DROP && !RX_EOF_N) begin
        state_n = S_IDLE;
      end
    end
  end

  // RX state and write pointers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      wr_commit <= '0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      wr_commit <= wr_commit_n;
    end
  end

  // Frame storage: data, REM and the four delimiters per word.
  always_ff @(posedge CLK) begin
    if (mem_we)
      mem[wr_addr[AW-1:0]] <= {RX_DATA, RX_REM, RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N};
  end

  assign tx_take     = tx_vld && !TX_DST_RDY_N;
  assign tx_load     = (rd_ptr != rd_lim) && (!tx_vld || tx_take);
  assign tx_eof_take = tx_take && !tx_word[2];

  // Output register; the read limit trails the commit pointer by one cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_vld  <= 1'b0;
      tx_word <= {{(DATA_WIDTH + REM_W){1'b0}}, 4'b1111};
      rd_ptr  <= '0;
      rd_lim  <= '0;
    end else begin
      rd_lim <= wr_commit;
      if (tx_load) begin
        tx_word <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + ONE_P;
        tx_vld  <= 1'b1;
      end else if (tx_take) begin
        tx_vld <= 1'b0;
      end
    end
  end

  // Committed frames not yet fully sent.
  always_ff @(posedge CLK) begin
    if (RESET)
      frame_cnt <= '0;
    else if (frame_commit && !tx_eof_take)
      frame_cnt <= frame_cnt + ONE_P;
    else if (!frame_commit && tx_eof_take)
      frame_cnt <= frame_cnt - ONE_P;
  end

  assign {TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N} = tx_word;
  assign TX_SRC_RDY_N = !tx_vld;
  assign RX_DST_RDY_N = !rx_rdy;
  assign FRAME_RDY    = frame_cnt;
  assign FREE         = ITEMS_P - occ;
  assign FULL         = full;
  assign EMPTY        = (frame_cnt == '0);

`ifdef FL_FRAME_FIFO_STATS_EN
  logic [1:0]  drop_inc;
  logic [32:0] drop_sum;
  logic [31:0] stat_acc, stat_drop;

  // Frames dropped this cycle: a partial frame cut by SOF plus a discarded or overflowed one.
  always_comb begin
    drop_inc = 2'd0;
    if (rx_xfer) begin
      if (!RX_SOF_N)
        drop_inc = {1'b0, state == S_WRITE} + {1'b0, !RX_EOF_N && RX_DISCARD};
      else if (state == S_IDLE)
        drop_inc = 2'd1;
      else if (state == S_WRITE)
        drop_inc = {1'b0, !RX_EOF_N ? RX_DISCARD : (inprog == LAST_P)};
    end
  end

  assign drop_sum = {1'b0, stat_drop} + {31'd0, drop_inc};

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge CLK) begin
    if (RESET || STAT_CLR) begin
      stat_acc  <= '0;
      stat_drop <= '0;
    end else begin
      if (frame_commit && stat_acc != 32'hFFFF_FFFF)
        stat_acc <= stat_acc + 32'd1;
      stat_drop <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    end
  end

  assign STAT_ACCEPTED = stat_acc;
  assign STAT_DROPPED  = stat_drop;
`endif

endmodule
